// File: rtl/alu_seq.sv
// Registered ALU with Start/Done handshake and an optional shift-add multiplier.
// Define ALU_MUL_EN to build the MUL opcode and the MULT sequencer.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Operacioni,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] ResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             CarryOut,
  output logic             Negative,
  output logic             IllegalOp
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic             accept;
  logic             fire;
  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic             slt;
  logic [WIDTH-1:0] res;
  logic             v_f;
  logic             c_f;
  logic             ill;

  assign accept = Start & ~Busy;

  // SLT reuses the subtractor: signed less-than is sign XOR overflow
  assign sub   = (Operacioni == OP_SUB) || (Operacioni == OP_SLT);
  assign b_eff = sub ? ~B : B;
  assign sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign ovf   = (A[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
  assign slt   = sum[WIDTH-1] ^ ovf;

  always_comb begin
    res = '0;
    v_f = 1'b0;
    c_f = 1'b0;
    ill = 1'b0;
    unique case (Operacioni)
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_ADD,
      OP_SUB: begin
        res = sum[WIDTH-1:0];
        v_f = ovf;
        c_f = sum[WIDTH];
      end
      OP_XOR: res = A ^ B;
      OP_NOR: res = ~(A | B);
      OP_SLT: res = {{(WIDTH-1){1'b0}}, slt};
      OP_MUL: begin
`ifndef ALU_MUL_EN
        ill = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    MULT = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               start_mul;
  logic               mul_last;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [CW-1:0]      cnt;

  assign fire      = accept && (Operacioni != OP_MUL);
  assign start_mul = accept && (Operacioni == OP_MUL);
  assign mul_last  = (state == MULT) && (cnt == CW'(1));
  assign acc_nxt   = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start_mul) state_nxt = MULT;
      MULT: if (mul_last)  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == MULT);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start_mul) begin
      mcand  <= {{WIDTH{1'b0}}, A};
      mplier <= B;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end else if (state == MULT) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end
`else
  assign fire     = accept;
  assign Busy     = 1'b0;
  assign ResultHi = '0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Done      <= 1'b0;
      Result    <= '0;
`ifdef ALU_MUL_EN
      ResultHi  <= '0;
`endif
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      CarryOut  <= 1'b0;
      Negative  <= 1'b0;
      IllegalOp <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (fire) begin
        Done      <= 1'b1;
        Result    <= res;
`ifdef ALU_MUL_EN
        ResultHi  <= '0;
`endif
        Zero      <= (res == '0);
        Overflow  <= v_f;
        CarryOut  <= c_f;
        Negative  <= res[WIDTH-1];
        IllegalOp <= ill;
      end
`ifdef ALU_MUL_EN
      else if (mul_last) begin
        Done      <= 1'b1;
        Result    <= acc_nxt[WIDTH-1:0];
        ResultHi  <= acc_nxt[2*WIDTH-1:WIDTH];
        Zero      <= (acc_nxt == '0);
        Overflow  <= |acc_nxt[2*WIDTH-1:WIDTH];
        CarryOut  <= 1'b0;
        Negative  <= acc_nxt[WIDTH-1];
        IllegalOp <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq; covers the MUL sequencer when ALU_MUL_EN
// is defined and the illegal-opcode path otherwise.
module tb_alu_seq;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   Operacioni;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic [W-1:0] ResultHi;
  logic         Zero;
  logic         Overflow;
  logic         CarryOut;
  logic         Negative;
  logic         IllegalOp;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         v;
    logic         c;
    logic         n;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   dones  = 0;
  logic busy_seen = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .A          (A),
    .B          (B),
    .Operacioni (Operacioni),
    .Busy       (Busy),
    .Done       (Done),
    .Result     (Result),
    .ResultHi   (ResultHi),
    .Zero       (Zero),
    .Overflow   (Overflow),
    .CarryOut   (CarryOut),
    .Negative   (Negative),
    .IllegalOp  (IllegalOp)
  );

  always #5 Clock = ~Clock;

  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [2*W-1:0] p;
    e = '0;
    s = '0;
    p = '0;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd3: e.res = a ^ b;
      3'd4: e.res = ~(a | b);
      3'd5: begin
        e.res = a - b;
        e.c = (a >= b);
        e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      3'd6: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: begin
`ifdef ALU_MUL_EN
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        e.res = p[W-1:0];
        e.hi = p[2*W-1:W];
        e.v = (e.hi != '0);
`else
        e.ill = 1'b1;
`endif
      end
    endcase
    e.n = e.res[W-1];
    e.z = ({e.hi, e.res} == '0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [2:0] op, input logic [W-1:0] a,
                    input logic [W-1:0] b);
    @(negedge Clock);
    Start = 1'b1;
    A = a;
    B = b;
    Operacioni = op;
    sb.push_back(model(op, a, b));
  endtask

  task automatic idle();
    @(negedge Clock);
    Start = 1'b0;
  endtask

  always @(negedge Clock) begin
    exp_t o;
    exp_t e;
    if (Busy) busy_seen = 1'b1;
    if (!Reset && Done) begin
      dones++;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_spurious queue=%0d required>0", sb.size());
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        o = {Result, ResultHi, Zero, Overflow, CarryOut, Negative, IllegalOp};
        checks++;
        assert (o === e) else begin
          errors++;
          $error("FAIL sb_result observed=%h expected=%h", o, e);
        end
      end
    end
  end

  initial begin
    int d0;
    int busy_n;
    int done_k;
    Reset = 1'b1;
    Start = 1'b0;
    A = '0;
    B = '0;
    Operacioni = 3'd0;
    #12;
    chk("reset_state", 64'({Busy, Done, Result, ResultHi, Zero, Overflow,
                            CarryOut, Negative, IllegalOp}), 64'(0));
    @(negedge Clock);
    Reset = 1'b0;

    go(3'd2, 16'h7FFF, 16'h0001);
    idle();
    chk("add_done", 64'(Done), 64'(1));
    chk("add_res", 64'(Result), 64'(16'h8000));
    chk("add_vcnz", 64'({Overflow, CarryOut, Negative, Zero}), 64'(4'b1010));

    go(3'd5, 16'h0005, 16'h0005);
    go(3'd6, 16'hFFFF, 16'h0001);
    chk("b2b_done1", 64'(Done), 64'(1));
    chk("sub_rzc", 64'({Result, Zero, CarryOut}), 64'({16'h0, 1'b1, 1'b1}));
    idle();
    chk("b2b_done2", 64'(Done), 64'(1));
    chk("slt_res", 64'(Result), 64'(16'h0001));
    @(negedge Clock);
    chk("done_pulse", 64'(Done), 64'(0));

    go(3'd5, 16'h0000, 16'h0001);
    go(3'd6, 16'h8000, 16'h7FFF);
    go(3'd2, 16'hFFFF, 16'h0001);
    go(3'd5, 16'h8000, 16'h0001);
    go(3'd6, 16'h7FFF, 16'h8000);
    for (int i = 0; i < 14; i++)
      go(3'(i % 7), W'($urandom), W'($urandom));
    idle();
    @(negedge Clock);

`ifdef ALU_MUL_EN
    go(3'd7, 16'h0100, 16'h0100);
    busy_n = 0;
    done_k = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clock);
      if (k == 1) Start = 1'b0;
      if (k == 5) begin
        Start = 1'b1;
        A = 16'h0003;
        B = 16'h0003;
      end
      if (k == 6) Start = 1'b0;
      if (Busy) busy_n++;
      if (Done && done_k == 0) done_k = k;
      if (k == 17)
        chk("mul_hi_lo", 64'({ResultHi, Result, Overflow, Zero}),
            64'({16'h0001, 16'h0000, 1'b1, 1'b0}));
    end
    chk("mul_busy_cycles", 64'(busy_n), 64'(16));
    chk("mul_done_cycle", 64'(done_k), 64'(17));

    go(3'd7, 16'hFFFF, 16'hFFFF);
    idle();
    repeat (16) @(negedge Clock);
    chk("mul_ffff", 64'({ResultHi, Result, Negative, Overflow}),
        64'({16'hFFFE, 16'h0001, 1'b0, 1'b1}));

    go(3'd7, 16'h1234, 16'h5678);
    idle();
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_mult", 64'({Busy, Done, Result, ResultHi, Zero, Overflow,
                             CarryOut, Negative, IllegalOp}), 64'(0));
    sb.delete();
    d0 = dones;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (20) @(negedge Clock);
    chk("no_done_after_rst", 64'(dones), 64'(d0));
`else
    go(3'd7, 16'h0003, 16'h0004);
    idle();
    chk("ill_done", 64'(Done), 64'(1));
    chk("ill_flags", 64'({Busy, Result, Zero, IllegalOp}),
        64'({1'b0, 16'h0000, 1'b1, 1'b1}));
    go(3'd0, 16'hF0F0, 16'h0FF0);
    idle();
    chk("and_clears_ill", 64'({Result, IllegalOp}), 64'({16'h00F0, 1'b0}));

    #2 Reset = 1'b1;
    #1;
    chk("rst_async", 64'({Busy, Done, Result, ResultHi, Zero, Overflow,
                          CarryOut, Negative, IllegalOp}), 64'(0));
    sb.delete();
    d0 = dones;
    @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("no_done_after_rst", 64'(dones), 64'(d0));
    chk("busy_never", 64'(busy_seen), 64'(0));
`endif

    go(3'd2, 16'h0002, 16'h0003);
    idle();
    chk("add_after_rst", 64'({Done, Result}), 64'({1'b1, 16'h0005}));

    repeat (5) @(negedge Clock);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
